pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 21 ++
 rtl/pipe_stage_reg_sat_counter.sv | 27 ++
 rtl/pipe_stage_reg.sv | 109 ++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-stage definitions: stall-vector layout, bubble fill value and stage state codes.
package pipe_stage_reg_pkg;

   localparam int   STALL_W  = 6;
   localparam logic STOP     = 1'b1;
   localparam logic NOP_FILL = 1'b0;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_VALID = 2'b01,
      ST_HELD  = 2'b10
   } stage_st_e;

   typedef enum logic [1:0] {
      ACT_FLUSH,
      ACT_CAPTURE,
      ACT_BUBBLE,
      ACT_HOLD
   } stage_act_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] cnt
);

   logic [CW-1:0] r_cnt;

   // NOTE: reset is sampled inside the clocked block, so it only acts on an edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with flush, bubble/hold stall handling,
// multi-cycle carry forwarding and saturating performance counters.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int              DW          = 64,
   parameter int              MW          = 66,
   parameter int              STAGE       = 3,
   parameter int              CW          = 16,
   parameter logic [DW-1:0]   NOP_PAYLOAD = {DW{NOP_FILL}}
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DW-1:0]      in_data,
   input  logic [MW-1:0]      mc_i,
   input  logic               clr_cnt,
   output logic               out_valid,
   output logic [DW-1:0]      out_data,
   output logic [MW-1:0]      mc_o,
   output logic [1:0]         st,
   output logic [CW-1:0]      bubble_cnt,
   output logic [CW-1:0]      stall_cnt
);

   logic          w_s;
   logic          w_d;
   logic          w_stall_unused;
   stage_act_e    w_act;

   logic          r_valid;
   logic [DW-1:0] r_data;
   logic [MW-1:0] r_mc;
   stage_st_e     r_st;

   assign w_s            = (stall[STAGE]   == STOP);
   assign w_d            = (stall[STAGE+1] == STOP);
   assign w_stall_unused = ^stall;

   always_comb begin
      w_act = ACT_HOLD;
      if (flush) begin
         w_act = ACT_FLUSH;
      end else if (!w_s) begin
         w_act = ACT_CAPTURE;
      end else if (!w_d) begin
         w_act = ACT_BUBBLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_data  <= NOP_PAYLOAD;
         r_mc    <= '0;
         r_st    <= ST_EMPTY;
      end else begin
         unique case (w_act)
            ACT_FLUSH: begin
               r_valid <= 1'b0;
               r_data  <= NOP_PAYLOAD;
               r_mc    <= '0;
               r_st    <= ST_EMPTY;
            end
            ACT_CAPTURE: begin
               r_valid <= in_valid;
               r_data  <= in_valid ? in_data : NOP_PAYLOAD;
               r_mc    <= '0;
               r_st    <= in_valid ? ST_VALID : ST_EMPTY;
            end
            ACT_BUBBLE: begin
               r_valid <= 1'b0;
               r_data  <= NOP_PAYLOAD;
               r_mc    <= mc_i;
               r_st    <= ST_EMPTY;
            end
            default: begin
               // Downstream is stalled too: keep the payload, keep forwarding the carry.
               r_mc    <= mc_i;
               r_st    <= r_valid ? ST_HELD : ST_EMPTY;
            end
         endcase
      end
   end

   sat_counter #(.CW(CW)) u_bubble_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_act == ACT_BUBBLE),
      .clr (clr_cnt),
      .cnt (bubble_cnt)
   );

   sat_counter #(.CW(CW)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_s),
      .clr (clr_cnt),
      .cnt (stall_cnt)
   );

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign mc_o      = r_mc;
   assign st        = r_st;

endmodule
